// File: rtl/fpu_pkg.sv
// Shared FPU constants: mantissa width and the requester-ID width helper.
package fpu_pkg;

  localparam int MANT_W = 28;

  typedef logic [MANT_W-1:0] mant_t;

  // At least one bit so that a 1- or 2-requester build still has a usable ID field.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mant_add_arbiter_if.sv
// Requester-side and result-side bundle for the shared mantissa adder.
interface mant_add_arbiter_if #(parameter int NREQ = 4);

  localparam int IDW = fpu_pkg::id_width(NREQ);

  logic [NREQ-1:0]                     req_valid;
  logic [NREQ-1:0]                     req_ready;
  logic [NREQ-1:0]                     req_sub;
  logic [NREQ-1:0][fpu_pkg::MANT_W-1:0] req_a;
  logic [NREQ-1:0][fpu_pkg::MANT_W-1:0] req_b;
  logic                                rsp_valid;
  logic                                rsp_ready;
  logic [IDW-1:0]                      rsp_id;
  logic [fpu_pkg::MANT_W-1:0]          rsp_sum;
  logic                                rsp_co;

  modport master (
    output req_valid, req_sub, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co
  );

  modport slave (
    input  req_valid, req_sub, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co
  );

endinterface

// File: rtl/mant_add_arbiter_cla.sv
// 28-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module mant_add_arbiter_cla
  import fpu_pkg::*;
(
  input  logic [MANT_W-1:0] a_i,
  input  logic [MANT_W-1:0] b_i,
  input  logic              ci_i,
  output logic [MANT_W-1:0] s_o,
  output logic              co_o
);

  logic [MANT_W-1:0] g;
  logic [MANT_W-1:0] p;
  logic [MANT_W:0]   c;

  // Carries built in a function so the vector is never read back within its own process.
  function automatic logic [MANT_W:0] carries(input logic [MANT_W-1:0] gg,
                                              input logic [MANT_W-1:0] pp,
                                              input logic              cin);
    logic [MANT_W:0] cc;
    logic            grp_g;
    logic            grp_p;
    cc    = '0;
    cc[0] = cin;
    for (int k = 0; k < MANT_W; k += 4) begin
      grp_g = gg[k+3] | (pp[k+3] & gg[k+2]) | (pp[k+3] & pp[k+2] & gg[k+1])
            | (pp[k+3] & pp[k+2] & pp[k+1] & gg[k]);
      grp_p = &pp[k+:4];
      cc[k+1] = gg[k] | (pp[k] & cc[k]);
      cc[k+2] = gg[k+1] | (pp[k+1] & gg[k]) | (pp[k+1] & pp[k] & cc[k]);
      cc[k+3] = gg[k+2] | (pp[k+2] & gg[k+1]) | (pp[k+2] & pp[k+1] & gg[k])
              | (pp[k+2] & pp[k+1] & pp[k] & cc[k]);
      cc[k+4] = grp_g | (grp_p & cc[k]);
    end
    return cc;
  endfunction

  assign g    = a_i & b_i;
  assign p    = a_i ^ b_i;
  assign c    = carries(g, p, ci_i);
  assign s_o  = p ^ c[MANT_W-1:0];
  assign co_o = c[MANT_W];

endmodule

// File: rtl/mant_add_arbiter_rr.sv
// Round-robin arbiter: first valid at or above ptr (mod N); ptr moves past each accept.
module rr_arbiter
  import fpu_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  input  logic          acc_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          any_req;

  // Scan from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    int k;
    k       = 0;
    idx_o   = '0;
    any_req = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      k = (int'(ptr_q) + off) % N;
      if (req_i[k[IW-1:0]]) begin
        idx_o   = k[IW-1:0];
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (any_req && en_i) gnt_o[idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (acc_i) ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mant_add_arbiter.sv
// Shares one mantissa CLA among NREQ requesters; result registered with the requester ID.
module mant_add_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic               clk,
  input logic               rst_n,
  mant_add_arbiter_if.slave bus
);

  localparam int IDW = id_width(NREQ);

  logic            stage_free;
  logic            accept;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  mant_t           add_a;
  mant_t           add_b;
  mant_t           add_s;
  logic            add_ci;
  logic            add_co;

  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
  mant_t           rsp_sum_q,   rsp_sum_d;
  logic            rsp_co_q,    rsp_co_d;

  assign stage_free = !rsp_valid_q || bus.rsp_ready;

  // Reset gates the enable so no requester sees ready while rst_n is low.
  rr_arbiter #(.N(NREQ)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (bus.req_valid),
    .en_i  (stage_free && rst_n),
    .acc_i (accept),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign bus.req_ready = gnt;
  assign accept        = |(bus.req_valid & gnt);

  // Subtract as A + ~B + 1.
  assign add_a  = bus.req_a[gnt_idx];
  assign add_b  = bus.req_sub[gnt_idx] ? ~bus.req_b[gnt_idx] : bus.req_b[gnt_idx];
  assign add_ci = bus.req_sub[gnt_idx];

  mant_add_arbiter_cla u_cla (
    .a_i  (add_a),
    .b_i  (add_b),
    .ci_i (add_ci),
    .s_o  (add_s),
    .co_o (add_co)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_co_d    = rsp_co_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_sum_d   = add_s;
      rsp_co_d    = add_co;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_co_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_co_q    <= rsp_co_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_co    = rsp_co_q;

endmodule

// File: tb/tb_mant_add_arbiter.sv
// Directed bench for mant_add_arbiter with a reference grant model and result scoreboard.
module tb_mant_add_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [27:0] sum;
    logic        co;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t       sb[$];
  logic [1:0] mptr;
  logic       mvalid;
  logic       last_acc;
  int         last_id;
  int         acc_cnt;
  logic       seen0;

  mant_add_arbiter_if #(.NREQ(4)) bus ();

  mant_add_arbiter #(.NREQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check grant before the edge, update the model, check the result stage after.
  task automatic cyc();
    int         g;
    logic [1:0] k;
    logic [3:0] exp_rdy;
    logic       acc;
    logic [28:0] wide;
    exp_t       e;
    @(negedge clk);
    g = -1;
    for (int off = 3; off >= 0; off--) begin
      k = mptr + 2'(off);
      if (bus.req_valid[k]) g = int'(k);
    end
    exp_rdy = 4'b0000;
    if (g >= 0 && rst_n === 1'b1 && (!mvalid || bus.rsp_ready)) exp_rdy = 4'b0001 << g;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    acc = (exp_rdy != 4'b0000);
    e   = '0;
    if (acc) begin
      e.id = 2'(g);
      if (bus.req_sub[g]) begin
        e.sum = bus.req_a[g] - bus.req_b[g];
        e.co  = (bus.req_a[g] >= bus.req_b[g]);
      end else begin
        wide  = {1'b0, bus.req_a[g]} + {1'b0, bus.req_b[g]};
        e.sum = wide[27:0];
        e.co  = wide[28];
      end
    end
    @(posedge clk);
    #1;
    if (rst_n !== 1'b1) begin
      sb.delete();
      mptr = 2'd0;
      acc  = 1'b0;
    end else begin
      if (mvalid && bus.rsp_ready) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(e);
        mptr = 2'(g + 1);
      end
    end
    mvalid = (sb.size() > 0);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(mvalid));
    if (mvalid) begin
      chk("rsp_id",  32'(bus.rsp_id),  32'(sb[0].id));
      chk("rsp_sum", 32'(bus.rsp_sum), 32'(sb[0].sum));
      chk("rsp_co",  32'(bus.rsp_co),  32'(sb[0].co));
    end
    last_acc = acc;
    last_id  = acc ? g : -1;
  endtask

  task automatic chk_zero_outputs();
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_sum",   32'(bus.rsp_sum),   32'd0);
    chk("rst_co",    32'(bus.rsp_co),    32'd0);
  endtask

  task automatic set_req(input int i, input logic v, input logic [27:0] a,
                         input logic [27:0] b, input logic s);
    bus.req_valid[i] = v;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
    bus.req_sub[i]   = s;
  endtask

  initial begin
    mptr     = 2'd0;
    mvalid   = 1'b0;
    last_acc = 1'b0;
    last_id  = -1;
    rst_n    = 1'b0;
    bus.req_valid = '0;
    bus.req_sub   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    chk_zero_outputs();

    // Add with carry out of the top bit
    set_req(0, 1'b1, 28'hFFFFFFF, 28'h0000001, 1'b0);
    cyc();
    chk("add_id",  32'(bus.rsp_id),  32'd0);
    chk("add_sum", 32'(bus.rsp_sum), 32'h0000000);
    chk("add_co",  32'(bus.rsp_co),  32'd1);
    bus.req_valid[0] = 1'b0;
    cyc();

    // Subtract without and with borrow
    set_req(2, 1'b1, 28'h0000010, 28'h0000003, 1'b1);
    cyc();
    chk("sub1_sum", 32'(bus.rsp_sum), 32'h000000D);
    chk("sub1_co",  32'(bus.rsp_co),  32'd1);
    set_req(2, 1'b1, 28'h0000003, 28'h0000010, 1'b1);
    cyc();
    chk("sub2_sum", 32'(bus.rsp_sum), 32'hFFFFFF3);
    chk("sub2_co",  32'(bus.rsp_co),  32'd0);
    bus.req_valid[2] = 1'b0;
    cyc();

    // Round robin from a fresh pointer with all requesters valid
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b1, 28'($urandom), 28'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rr_seq", 32'(last_id), 32'(i % 4));
      if (last_acc)
        set_req(last_id, 1'b1, 28'($urandom), 28'($urandom), 1'($urandom_range(0, 1)));
    end

    // Backpressure: stall three cycles, then drain and accept together
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    bus.rsp_ready = 1'b1;
    cyc();
    chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_id",    32'(bus.rsp_id),    32'd1);
    bus.req_valid = 4'b0000;

    // Fairness: requester 0 held, requester 3 toggling
    set_req(0, 1'b1, 28'h1234567, 28'h0ABCDEF, 1'b0);
    acc_cnt = 0;
    seen0   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!seen0) begin
        bus.req_valid[3] = ~bus.req_valid[3];
        cyc();
        if (last_acc) acc_cnt++;
        if (last_id == 0) seen0 = 1'b1;
      end
    end
    chk("fair_seen0", 32'(seen0), 32'd1);
    chk("fair_within", 32'(acc_cnt <= 4), 32'd1);
    bus.req_valid = 4'b0000;
    cyc();

    // Reset with a pending result and ptr at 2
    set_req(1, 1'b1, 28'h0000005, 28'h0000007, 1'b0);
    cyc();
    chk("pre_rst_id", 32'(bus.rsp_id), 32'd1);
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk_zero_outputs();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    cyc();
    chk("post_rst_id", 32'(last_id), 32'd0);
    bus.req_valid = 4'b0000;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
